// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the decode/handshake signals exchanged between the pipeline
//   datapath and the hazard controller.
//   master : pipeline side (drives instructions, branch and mult/div status,
//            receives stall/flush/start controls)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if;
  logic [31:0] fd_instruction;
  logic [31:0] de_instruction;
  logic        branch_taken;
  logic        multdiv_result_ready;
  logic        multdiv_exception;

  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_de;
  logic        nop_de;
  logic        nop_fd;
  logic        nop_em;
  logic        md_result_valid;
  logic        md_error;

  modport master (
    output fd_instruction, de_instruction, branch_taken,
           multdiv_result_ready, multdiv_exception,
    input  ctrl_mult, ctrl_div, stall_pc, stall_fd, stall_de,
           nop_de, nop_fd, nop_em, md_result_valid, md_error
  );

  modport slave (
    input  fd_instruction, de_instruction, branch_taken,
           multdiv_result_ready, multdiv_exception,
    output ctrl_mult, ctrl_div, stall_pc, stall_fd, stall_de,
           nop_de, nop_fd, nop_em, md_result_valid, md_error
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush/sequencing controller for the 5-stage pipeline. Decodes the
//   F/D and D/X instructions, launches and supervises the multi-cycle
//   mult/div unit, inserts load-use bubbles and flushes wrong-path
//   instructions on a taken branch.
//   Ports:
//     clock  : pipeline clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : pipeline_hazard_ctrl_if.slave (instructions, branch, mult/div
//              status in; start pulses, latch stalls and nop injects out)
//   Parameter:
//     MD_TIMEOUT : max BUSY cycles waiting for result_ready (2..255)
//
//   state | meaning
//   IDLE  | no mult/div in flight; a mul/div in X is launched this cycle
//   BUSY  | waiting for result_ready or timeout; pipeline frozen
//   DONE  | X/M captures the result; D/X advances
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input logic             clock,
  input logic             reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [7:0] CNT_LAST = 8'(MD_TIMEOUT - 1);

  md_state_t  state;
  logic [7:0] cnt;
  logic       err;

  // F/D decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] fd_s2;
  logic       fd_s2_valid;

  // D/X decode
  logic [4:0] de_op, de_rd, de_alu;
  logic       de_lw, de_mul, de_div;

  logic       load_use;
  logic       md_start;
  logic       stall_set;

  assign fd_op = bus.fd_instruction[31:27];
  assign fd_rd = bus.fd_instruction[26:22];
  assign fd_rs = bus.fd_instruction[21:17];
  assign fd_rt = bus.fd_instruction[16:12];

  assign de_op  = bus.de_instruction[31:27];
  assign de_rd  = bus.de_instruction[26:22];
  assign de_alu = bus.de_instruction[6:2];

  assign de_lw  = (de_op == OP_LW);
  assign de_mul = (de_op == OP_RTYPE) && (de_alu == ALU_MUL);
  assign de_div = (de_op == OP_RTYPE) && (de_alu == ALU_DIV);

  // Second source: rt for R-type; stores and compares read rd as a source.
  always_comb begin
    fd_s2       = 5'd0;
    fd_s2_valid = 1'b0;
    if (fd_op == OP_RTYPE) begin
      fd_s2       = fd_rt;
      fd_s2_valid = 1'b1;
    end else if ((fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT)) begin
      fd_s2       = fd_rd;
      fd_s2_valid = 1'b1;
    end
  end

  // de_rd != 0 keeps r0 from ever matching either source.
  assign load_use = de_lw && (de_rd != 5'd0) &&
                    ((de_rd == fd_rs) || (fd_s2_valid && (de_rd == fd_s2)));

  // No launch while reset is held, so the mul/div restarts cleanly after release.
  assign md_start  = (state == IDLE) && (de_mul || de_div) && !reset;
  assign stall_set = md_start || (state == BUSY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (de_mul || de_div) begin
            state <= BUSY;
            cnt   <= 8'd0;
          end
        end
        BUSY: begin
          if (bus.multdiv_result_ready) begin
            state <= DONE;
            err   <= bus.multdiv_exception;
          end else if (cnt == CNT_LAST) begin
            state <= DONE;
            err   <= 1'b1;
          end
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.ctrl_mult       = md_start && de_mul;
    bus.ctrl_div        = md_start && de_div;
    bus.stall_pc        = 1'b0;
    bus.stall_fd        = 1'b0;
    bus.stall_de        = 1'b0;
    bus.nop_de          = 1'b0;
    bus.nop_fd          = 1'b0;
    bus.nop_em          = 1'b0;
    bus.md_result_valid = (state == DONE);
    bus.md_error        = (state == DONE) && err;

    if (stall_set) begin
      // Freeze everything up to X and bubble X/M until the result arrives.
      bus.stall_pc = 1'b1;
      bus.stall_fd = 1'b1;
      bus.stall_de = 1'b1;
      bus.nop_em   = 1'b1;
    end else if (bus.branch_taken) begin
      bus.nop_fd = 1'b1;
      bus.nop_de = 1'b1;
    end else if (load_use) begin
      bus.stall_pc = 1'b1;
      bus.stall_fd = 1'b1;
      bus.nop_de   = 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.fd_instruction[11:0],
                         bus.de_instruction[21:7], bus.de_instruction[1:0]};

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/sequencing controller for the 5-stage pipeline (F, D, X, M, W). It decodes the instructions held in the F/D and D/X latches. It launches and supervises the multi-cycle mult/div unit in X, inserts load-use bubbles, and flushes wrong-path instructions on a taken branch. Its outputs drive the PC, F/D, D/X and X/M latch enables and nop-inject muxes. Forwarding itself is handled separately and is unaffected.

## Interface
- MD_TIMEOUT, 64: max cycles the controller waits for multdiv_result_ready before aborting; legal range 2..255.
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fd_instruction  in  32  instruction in the F/D latch (in D).
- de_instruction  in  32  instruction in the D/X latch (in X).
- branch_taken  in  1  X-stage branch/jump resolved taken this cycle.
- multdiv_result_ready  in  1  mult/div unit result valid (level).
- multdiv_exception  in  1  mult/div unit exception, valid with result_ready.
- ctrl_mult  out  1  one-cycle start pulse for multiply.
- ctrl_div  out  1  one-cycle start pulse for divide.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold F/D latch.
- stall_de  out  1  hold D/X latch.
- nop_de  out  1  load nop into D/X instead of D output.
- nop_fd  out  1  load nop into F/D (flush).
- nop_em  out  1  load nop into X/M.
- md_result_valid  out  1  X/M latch must capture the mult/div result this cycle.
- md_error  out  1  result-capture cycle carries exception or timeout.

## Operation
- Field decode (ISA): opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
  - lw = opcode 01000; mul = opcode 00000 + ALU op 00110; div = opcode 00000 + ALU op 00111.
  - bne = 00010; blt = 00110; sw = 00111.
- D-stage sources:
  - S1 = rs for all instructions.
  - S2 = rt for R-type.
  - S2 = rd for sw/bne/blt.
  - No S2 otherwise.
  - Register 0 never matches.
- Load-use hazard (LU): de is lw, de.rd != 0, and de.rd equals fd S1 or a valid fd S2.
- Multdiv FSM states: IDLE, BUSY, DONE; 8-bit cycle counter cnt.
  - IDLE: de is mul/div → ctrl_mult/ctrl_div = 1 (combinational) and assert stall set; next BUSY, cnt = 0.
  - BUSY: hold stall set; cnt += 1.
  - BUSY exit on multdiv_result_ready = 1 → next DONE, latch err = multdiv_exception.
  - BUSY exit on cnt == MD_TIMEOUT-1 without ready → next DONE, err = 1.
  - DONE: md_result_valid = 1, md_error = err; no stalls (D/X advances); next IDLE. No start pulse in DONE even though de still shows mul/div.
- Stall set (IDLE-with-mul/div and BUSY): stall_pc = stall_fd = stall_de = nop_em = 1, nop_de = nop_fd = 0.
- Outside stall set, priority branch flush > load-use:
  - branch_taken → nop_fd = nop_de = 1, no stalls.
  - Else LU → stall_pc = stall_fd = 1, nop_de = 1.
  - Else all outputs 0.
- LU, mul/div start and flush are combinational from current inputs and state; the state, cnt and err registers are the only storage.

## Timing
- Reset: state IDLE, cnt 0, err 0; all outputs 0 except combinational LU/flush terms from inputs. No start pulse is issued while reset is high.
- Start pulse: exactly one cycle, in the first cycle the mul/div occupies X.
- Result capture: one cycle after the first cycle with result_ready high in BUSY. Earliest DONE is cycle 2 after start, if ready is high in cycle 1.
- Total pipeline hold: N+1 stall cycles for a unit asserting ready N cycles after start.
- Timeout: DONE at cycle MD_TIMEOUT+1 after start, with md_error = 1.
- result_ready high in IDLE or DONE is ignored.
- Back-to-back mul/div: the second starts in the IDLE cycle right after DONE.
- Reset mid-BUSY: FSM returns to IDLE at once; the mul/div still in X restarts with a fresh pulse after reset releases.

## Test plan
- Load-use: de = lw r5, fd = add r6,r5,r7 → one cycle of stall_pc = stall_fd = nop_de = 1. Same with de.rd = r0 → no stall.
- sw source: de = lw r3, fd = sw r3,0(r4) → LU stall. fd = addi r3,r4,1 (I-type, rd is a destination) → no stall.
- Multiply: de = mul, ready asserted 4 cycles after start →
  - ctrl_mult high 1 cycle;
  - stalls + nop_em for 5 cycles;
  - md_result_valid 1 cycle, md_error 0.
- Divide exception: ready + exception asserted 2 cycles after start → md_result_valid = md_error = 1 in cycle 3.
- Timeout with MD_TIMEOUT = 8 and ready never high → DONE at cycle 9, md_error = 1, then IDLE.
- Flush priority: branch_taken with LU present → nop_fd = nop_de = 1, stall_pc = 0. Reset asserted in BUSY → outputs drop that cycle, new ctrl pulse after release.
